serial_cla_adder: RTL



---
 rtl/serial_cla_pkg.sv | 8 +
 rtl/carry_gen_adder.sv | 28 ++
 rtl/serial_cla_adder.sv | 82 ++++++++
 3 files changed

// File: rtl/serial_cla_pkg.sv
// serial_cla_pkg: shared FSM state, slice width and counter sizing for serial_cla_adder
package serial_cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 4;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/carry_gen_adder.sv
// carry_gen_adder: 4-bit carry-lookahead slice; c3 tap exists only with SERIAL_CLA_OVF_EN
module carry_gen_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
`ifdef SERIAL_CLA_OVF_EN
  output logic       c3,
`endif
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p & cin);
  end
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
`ifdef SERIAL_CLA_OVF_EN
  assign c3 = c[3];
`endif
endmodule

// File: rtl/serial_cla_adder.sv
// serial_cla_adder: WIDTH-bit add done one 4-bit CLA chunk per clock; SERIAL_CLA_OVF_EN adds ovf output
module serial_cla_adder
  import serial_cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_CLA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NCHUNK = WIDTH / SLICE_W;
  localparam int CW = cnt_w(NCHUNK);
  state_t state, next;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic carry, last, s_cout;
  logic [SLICE_W-1:0] s_sum;
`ifdef SERIAL_CLA_OVF_EN
  logic s_c3;
`endif
  assign last = cnt == CW'(NCHUNK - 1);
  carry_gen_adder u_slice (
    .a(a_r[SLICE_W*cnt +: SLICE_W]),
    .b(b_r[SLICE_W*cnt +: SLICE_W]),
    .cin(carry),
    .sum(s_sum),
`ifdef SERIAL_CLA_OVF_EN
    .c3(s_c3),
`endif
    .cout(s_cout)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : next;
  always_comb
    next = state == IDLE ? (in_valid ? RUN : IDLE) :
           state == RUN  ? (last ? DONE : RUN) :
                           (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      sum[SLICE_W*cnt +: SLICE_W] <= s_sum;
      carry <= s_cout;
      cnt   <= last ? cnt : cnt + 1'b1;
      if (last) begin
        cout <= s_cout;
`ifdef SERIAL_CLA_OVF_EN
        ovf  <= s_c3 ^ s_cout;
`endif
      end
    end
  end
endmodule
